// File: rtl/uart_tx.sv
// 8N1 UART transmitter: valid/ready byte intake, one-deep holding register,
// internal baud divider. Line is idle-high, data goes out LSB first.
module uart_tx #(
    parameter int CLK_FREQ  = 12000000,
    parameter int BAUD_RATE = 9600,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int DIV   = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    // Index of the final stop bit; anything other than 2 stop bits means 1.
    localparam logic STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic             stop_q, stop_d;
    logic             hold_full_q, hold_full_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       hold_q, hold_d;
    logic             tx_d, busy_d, done_d;

    logic bit_end;
    logic last_stop;
    logic accept;
    logic direct_load;

    assign ready       = rst && !hold_full_q;
    assign accept      = valid && ready;
    assign bit_end     = (cnt_q == CNT_LAST);
    assign last_stop   = (state_q == STOP) && bit_end && (stop_q == STOP_LAST);
    assign direct_load = accept && ((state_q == IDLE) || (last_stop && !hold_full_q));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        stop_d      = stop_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        hold_d      = hold_q;

        if (state_q != IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        if (accept && !direct_load) begin
            hold_d      = data;
            hold_full_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (direct_load) begin
                    shift_d = data;
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_d   = 3'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        stop_d  = 1'b0;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop_q == STOP_LAST) begin
                        // Held byte wins; otherwise a same-cycle accept chains directly.
                        if (hold_full_q) begin
                            shift_d     = hold_q;
                            hold_full_d = 1'b0;
                            state_d     = START;
                        end else if (direct_load) begin
                            shift_d = data;
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                        cnt_d = '0;
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next-state view so they line up with the state they describe.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[bit_d];
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == STOP) && (cnt_d == CNT_LAST) && (stop_d == STOP_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= 3'd0;
            stop_q      <= 1'b0;
            hold_full_q <= 1'b0;
            tx          <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            stop_q      <= stop_d;
            hold_full_q <= hold_full_d;
            tx          <= tx_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end

    // Byte storage carries no reset; hold_full and state qualify its contents.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        hold_q  <= hold_d;
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with DIV=16: a table of frame sequences checked
// against a bit-level line model and a mid-bit sampling receiver, plus reset cases.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data = 8'h00;
    logic       valid = 1'b0;
    logic       valid2 = 1'b0;
    logic       ready, tx, busy, done;
    logic       ready2, tx2, busy2, done2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLK_FREQ(160), .BAUD_RATE(10), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .data(data), .valid(valid),
        .ready(ready), .tx(tx), .busy(busy), .done(done)
    );

    uart_tx #(.CLK_FREQ(160), .BAUD_RATE(10), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .data(data), .valid(valid2),
        .ready(ready2), .tx(tx2), .busy(busy2), .done(done2)
    );

    // Receiver on dut's line: start at first low sample, bits sampled mid-period.
    logic [7:0] rx_q[$];
    int         rx_ferr = 0;
    bit         rx_busy = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_sh = 8'h00;
    logic       rx_rst_s;

    always @(posedge clk) begin
        rx_rst_s = rst;
        #1;
        if (!rx_rst_s) begin
            rx_busy = 1'b0;
        end else if (!rx_busy) begin
            if (tx === 1'b0) begin
                rx_busy = 1'b1;
                rx_cnt  = 1;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt == 8 && tx !== 1'b0) begin
                rx_busy = 1'b0;
                rx_ferr++;
            end else if (rx_cnt >= 24 && rx_cnt <= 136 && (rx_cnt % 16) == 8) begin
                rx_sh[3'((rx_cnt - 24) / 16)] = tx;
            end else if (rx_cnt == 152) begin
                if (tx !== 1'b1) rx_ferr++;
                rx_q.push_back(rx_sh);
                rx_busy = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic drive_valid(input int sel, input logic v);
        if (sel == 0) valid = v;
        else valid2 = v;
    endtask

    // Line level at position kk (1-based) within a frame of byte b.
    function automatic logic exp_tx(input logic [7:0] b, input int kk);
        if (kk <= 16) return 1'b0;
        if (kk <= 144) return b[3'((kk - 17) / 16)];
        return 1'b1;
    endfunction

    typedef struct {
        int         sel;
        int         n;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        int         per;
    } vec_t;

    vec_t vecs[8];

    task automatic run_seq(input int idx, input vec_t v);
        logic [7:0] bs[3];
        int   acc[3];
        int   dq[$];
        int   bad_tx, bad_busy, rdy_ret, nxt, f, kk, len;
        logic prev_rdy, r_s, t_s, bz_s, d_s, v_s, accept;
        bs[0] = v.b0; bs[1] = v.b1; bs[2] = v.b2;
        acc[0] = 0; acc[1] = -1; acc[2] = -1;
        bad_tx = 0; bad_busy = 0; rdy_ret = -1;
        len = v.per * v.n;
        data = v.b0;
        drive_valid(v.sel, 1'b1);
        tick();
        if (v.n == 1) begin
            drive_valid(v.sel, 1'b0);
            data = ~v.b0;
        end else begin
            data = v.b1;
        end
        nxt = 1;
        prev_rdy = 1'b1;
        for (int k = 1; k <= len; k++) begin
            r_s  = (v.sel == 0) ? ready : ready2;
            t_s  = (v.sel == 0) ? tx    : tx2;
            bz_s = (v.sel == 0) ? busy  : busy2;
            d_s  = (v.sel == 0) ? done  : done2;
            v_s  = (v.sel == 0) ? valid : valid2;
            if (r_s && !prev_rdy && rdy_ret < 0) rdy_ret = k;
            prev_rdy = r_s;
            f  = (k - 1) / v.per;
            kk = k - v.per * f;
            if (t_s !== exp_tx(bs[f], kk)) bad_tx++;
            if (bz_s !== 1'b1) bad_busy++;
            if (d_s === 1'b1) dq.push_back(k);
            accept = v_s && r_s;
            if (accept) acc[nxt] = k;
            tick();
            if (accept) begin
                nxt++;
                if (nxt < v.n) data = bs[nxt];
                else begin
                    drive_valid(v.sel, 1'b0);
                    data = ~data;
                end
            end
        end
        chk($sformatf("v%0d_tx_wave", idx), bad_tx, 0);
        chk($sformatf("v%0d_busy_in_frame", idx), bad_busy, 0);
        chk($sformatf("v%0d_done_count", idx), dq.size(), v.n);
        for (int i = 0; i < dq.size() && i < v.n; i++)
            chk($sformatf("v%0d_done_pos%0d", idx, i), dq[i], v.per * (i + 1));
        if (v.n >= 2) begin
            chk($sformatf("v%0d_hold_accept", idx), acc[1], 1);
            chk($sformatf("v%0d_ready_return", idx), rdy_ret, v.per + 1);
        end
        if (v.n == 3) chk($sformatf("v%0d_third_accept", idx), acc[2], v.per + 1);
        chk($sformatf("v%0d_busy_after", idx), (v.sel == 0) ? busy : busy2, 0);
        chk($sformatf("v%0d_tx_after", idx), (v.sel == 0) ? tx : tx2, 1);
        chk($sformatf("v%0d_done_after", idx), (v.sel == 0) ? done : done2, 0);
        if (v.sel == 0) begin
            chk($sformatf("v%0d_rx_count", idx), rx_q.size(), v.n);
            for (int i = 0; i < v.n && rx_q.size() > 0; i++)
                chk($sformatf("v%0d_rx_byte%0d", idx, i), rx_q.pop_front(), bs[i]);
            chk($sformatf("v%0d_rx_framing", idx), rx_ferr, 0);
            rx_q.delete();
        end
    endtask

    initial begin
        int bad;
        vecs[0] = '{0, 1, 8'hA5, 8'h00, 8'h00, 160};
        vecs[1] = '{0, 1, 8'h00, 8'h00, 8'h00, 160};
        vecs[2] = '{0, 1, 8'hFF, 8'h00, 8'h00, 160};
        vecs[3] = '{0, 1, 8'h01, 8'h00, 8'h00, 160};
        vecs[4] = '{0, 2, 8'h00, 8'hFF, 8'h00, 160};
        vecs[5] = '{0, 3, 8'h81, 8'h42, 8'h3C, 160};
        vecs[6] = '{1, 1, 8'h55, 8'h00, 8'h00, 176};
        vecs[7] = '{1, 2, 8'h55, 8'hC3, 8'h00, 176};

        // Reset held low
        repeat (3) tick();
        chk("rst_ready", ready, 0);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tx2", tx2, 1);

        // Idle after release
        rst = 1'b1;
        tick();
        bad = 0;
        for (int k = 0; k < 200; k++) begin
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || ready !== 1'b1) bad++;
            tick();
        end
        chk("idle_bad_cycles", bad, 0);
        chk("idle_rx_count", rx_q.size(), 0);

        for (int i = 0; i < 8; i++) run_seq(i, vecs[i]);

        // Reset during DATA bit 3 with a byte held
        data = 8'h5A;
        valid = 1'b1;
        tick();
        data = 8'h77;
        tick();
        valid = 1'b0;
        chk("abort_hold_full", ready, 0);
        for (int k = 2; k < 70; k++) tick();
        chk("abort_pre_tx", tx, exp_tx(8'h5A, 70));
        chk("abort_pre_busy", busy, 1);
        rst = 1'b0;
        tick();
        chk("abort_tx", tx, 1);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_ready_in_rst", ready, 0);
        rst = 1'b1;
        #1;
        chk("abort_ready_release", ready, 1);
        bad = 0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        chk("abort_quiet_cycles", bad, 0);
        chk("abort_rx_count", rx_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
